// File: rtl/status_register_unit.sv
// NZCV status register with in-flight S-instruction tracking for the ID-stage condition checker.
// Optional build macro STATUS_BYPASS_EN: flag and busy outputs forward next-state values combinationally.
module status_register_unit #(
    parameter int DATA_W = 32,
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exe_valid,
    input  logic              exe_s,
    input  logic              exe_arith,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_ovf,
    input  logic              shift_carry,
    input  logic              freeze,
    input  logic              flush,
    input  logic              issue_s,
    input  logic              psr_we,
    input  logic [3:0]        psr_wdata,
    output logic              n,
    output logic              z,
    output logic              c,
    output logic              v,
    output logic              flags_busy
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [3:0]        flags_q;
    logic [3:0]        flags_d;
    logic [PEND_W-1:0] count_q;
    logic [PEND_W-1:0] count_d;
    logic              busy_q;
    logic              commit;
    logic              issue;
    logic              res_n;
    logic              res_z;

    // flush only kills the younger instruction in ID; the EXE instruction still commits.
    assign commit = exe_valid & exe_s & ~freeze;
    assign issue  = issue_s & ~freeze & ~flush;
    assign res_n  = alu_result[DATA_W-1];
    assign res_z  = (alu_result == '0);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        flags_d = flags_q;
        if (psr_we) begin
            flags_d = psr_wdata;
        end else if (commit) begin
            flags_d[3] = res_n;
            flags_d[2] = res_z;
            flags_d[1] = exe_arith ? alu_carry : shift_carry;
            flags_d[0] = exe_arith ? alu_ovf : flags_q[0];
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({issue, commit})
            2'b10:   if (count_q != PEND_MAX) count_d = count_q + PEND_ONE;
            2'b01:   if (count_q != '0)       count_d = count_q - PEND_ONE;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 4'b0000;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            flags_q <= flags_d;
            count_q <= count_d;
            busy_q  <= (count_d != '0);
        end
    end

`ifdef STATUS_BYPASS_EN
    assign {n, z, c, v} = flags_d;
    assign flags_busy   = (count_d != '0);
`else
    assign {n, z, c, v} = flags_q;
    assign flags_busy   = busy_q;
`endif

endmodule

// File: tb/tb_status_register_unit.sv
// Self-checking bench for status_register_unit: table of single-commit vectors plus
// directed sequences for freeze, pending counter, reset and output latency.
module tb_status_register_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        exe_valid, exe_s, exe_arith;
    logic [31:0] alu_result;
    logic        alu_carry, alu_ovf, shift_carry;
    logic        freeze, flush, issue_s, psr_we;
    logic [3:0]  psr_wdata;
    logic        n, z, c, v, flags_busy;

    int n_checks = 0;
    int n_fail   = 0;

    status_register_unit #(.DATA_W(32), .PEND_W(2)) dut (
        .clk(clk), .rst(rst),
        .exe_valid(exe_valid), .exe_s(exe_s), .exe_arith(exe_arith),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
        .shift_carry(shift_carry), .freeze(freeze), .flush(flush),
        .issue_s(issue_s), .psr_we(psr_we), .psr_wdata(psr_wdata),
        .n(n), .z(z), .c(c), .v(v), .flags_busy(flags_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        s;
        logic        arith;
        logic        frz;
        logic        we;
        logic [3:0]  wdata;
        logic [31:0] res;
        logic        carry;
        logic        ovf;
        logic        sc;
        logic [3:0]  exp_nzcv;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic idle();
        exe_valid = 1'b0; exe_s = 1'b0; exe_arith = 1'b0;
        alu_result = '0; alu_carry = 1'b0; alu_ovf = 1'b0; shift_carry = 1'b0;
        freeze = 1'b0; flush = 1'b0; issue_s = 1'b0;
        psr_we = 1'b0; psr_wdata = 4'b0000;
    endtask

    // Let the applied inputs be captured, then return strobes to idle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_commit(input logic iss, input logic fl);
        exe_valid = 1'b1; exe_s = 1'b1; exe_arith = 1'b0;
        alu_result = 32'h1; issue_s = iss; flush = fl;
        tick();
    endtask

    task automatic do_issue(input logic fl);
        issue_s = 1'b1; flush = fl;
        tick();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_nzcv", {n, z, c, v}, 4'b0000);
        check("reset_busy", {3'b000, flags_busy}, 4'b0000);

        //            valid s  arith frz we wdata    res            carry ovf sc  expected
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 4'b0110};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 4'b1001};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0000_0005, 1'b1, 1'b0, 1'b0, 4'b0001};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 4'b0111};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 4'b0111};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 4'b0111};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1010, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 4'b1010};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'b1010};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0101, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'b0101};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 4'b1011};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 4'b0000};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'b1111};

        for (int i = 0; i < 12; i++) begin
            exe_valid = vecs[i].valid; exe_s = vecs[i].s; exe_arith = vecs[i].arith;
            freeze = vecs[i].frz; psr_we = vecs[i].we; psr_wdata = vecs[i].wdata;
            alu_result = vecs[i].res; alu_carry = vecs[i].carry;
            alu_ovf = vecs[i].ovf; shift_carry = vecs[i].sc;
            tick();
            check($sformatf("vec%0d_nzcv", i), {n, z, c, v}, vecs[i].exp_nzcv);
        end

        // Freeze held for three cycles over a pending arith commit; flags start at 1111.
        exe_valid = 1'b1; exe_s = 1'b1; exe_arith = 1'b1;
        alu_result = 32'h0; alu_carry = 1'b0; alu_ovf = 1'b0; freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("freeze_hold%0d", i), {n, z, c, v}, 4'b1111);
        end
        freeze = 1'b0;
        tick();
        check("freeze_release", {n, z, c, v}, 4'b0100);

        // Output latency: arith commit res=0, carry=1 seen before the capturing edge.
        psr_we = 1'b1; psr_wdata = 4'b0000;
        tick();
        exe_valid = 1'b1; exe_s = 1'b1; exe_arith = 1'b1;
        alu_result = 32'h0; alu_carry = 1'b1; alu_ovf = 1'b0;
        #1;
`ifdef STATUS_BYPASS_EN
        check("latency_same_cycle", {n, z, c, v}, 4'b0110);
`else
        check("latency_same_cycle", {n, z, c, v}, 4'b0000);
`endif
        tick();
        check("latency_next_cycle", {n, z, c, v}, 4'b0110);

        // Pending counter sequence.
        do_issue(1'b0);
        check("pend_issue1_busy", {3'b000, flags_busy}, 4'b0001);
        do_issue(1'b0);
        check("pend_issue2_busy", {3'b000, flags_busy}, 4'b0001);
        do_commit(1'b1, 1'b0);
        check("pend_commit_issue_busy", {3'b000, flags_busy}, 4'b0001);
        do_issue(1'b1);
        check("pend_flush_busy", {3'b000, flags_busy}, 4'b0001);
        do_commit(1'b0, 1'b0);
        check("pend_commit_a_busy", {3'b000, flags_busy}, 4'b0001);
        do_commit(1'b0, 1'b0);
        check("pend_commit_b_busy", {3'b000, flags_busy}, 4'b0000);
        do_commit(1'b0, 1'b0);
        check("pend_extra_commit_busy", {3'b000, flags_busy}, 4'b0000);
        do_issue(1'b0);
        check("pend_no_wrap_busy", {3'b000, flags_busy}, 4'b0001);
        do_commit(1'b0, 1'b0);
        check("pend_back_to_zero", {3'b000, flags_busy}, 4'b0000);

        // Freeze gates issue.
        issue_s = 1'b1; freeze = 1'b1;
        tick();
        check("pend_freeze_issue", {3'b000, flags_busy}, 4'b0000);

        // Saturation at 3: four issues, then three commits drain it.
        for (int i = 0; i < 4; i++) do_issue(1'b0);
        check("pend_sat_busy", {3'b000, flags_busy}, 4'b0001);
        do_commit(1'b0, 1'b0);
        do_commit(1'b0, 1'b0);
        check("pend_sat_two_left", {3'b000, flags_busy}, 4'b0001);
        do_commit(1'b0, 1'b0);
        check("pend_sat_drained", {3'b000, flags_busy}, 4'b0000);

        // Reset mid-run with flags 1111 and two pending instructions.
        psr_we = 1'b1; psr_wdata = 4'b1111;
        tick();
        do_issue(1'b0);
        do_issue(1'b0);
        check("midrst_pre_nzcv", {n, z, c, v}, 4'b1111);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_nzcv", {n, z, c, v}, 4'b0000);
        check("midrst_busy", {3'b000, flags_busy}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_busy", {3'b000, flags_busy}, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
